// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_pkg;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} lc3_state_e;

   localparam int unsigned LC3_MEM_LATENCY = 2;

   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;

endpackage

// File: rtl/lc3_mmio.sv
// LC-3 keyboard/display device registers, decoded on the full 16-bit address.
// Only instantiated when LC3_MMIO_EN is defined.
module lc3_mmio
   import lc3_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        complete,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   input  logic        dsr_ready,
   output logic        hit,
   output logic [15:0] rdata,
   output logic        ddr_valid,
   output logic [7:0]  ddr_data
);

   logic       kbsr_q;
   logic [7:0] kbdr_q;
   logic       ddr_valid_q;
   logic [7:0] ddr_data_q;

   assign hit = (addr == ADDR_KBSR) || (addr == ADDR_KBDR) ||
                (addr == ADDR_DSR)  || (addr == ADDR_DDR);

   always_comb begin
      rdata = 16'h0000;
      if (addr == ADDR_KBSR)      rdata = {kbsr_q, 15'b0};
      else if (addr == ADDR_KBDR) rdata = {8'h00, kbdr_q};
      else if (addr == ADDR_DSR)  rdata = {dsr_ready, 15'b0};
      else if (addr == ADDR_DDR)  rdata = {8'h00, ddr_data_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kbsr_q      <= 1'b0;
         kbdr_q      <= 8'h00;
         ddr_valid_q <= 1'b0;
         ddr_data_q  <= 8'h00;
      end else begin
         ddr_valid_q <= complete && wr && (addr == ADDR_DDR);
         if (complete && wr && (addr == ADDR_DDR)) ddr_data_q <= wdata;
         // A new keystroke wins over the clear caused by reading KBDR.
         if (kb_valid) begin
            kbsr_q <= 1'b1;
            kbdr_q <= kb_data;
         end else if (complete && !wr && (addr == ADDR_KBDR)) begin
            kbsr_q <= 1'b0;
         end
      end
   end

   assign ddr_valid = ddr_valid_q;
   assign ddr_data  = ddr_data_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: fixed-latency IDLE/BUSY/DONE handshake over a 2^ADDR_W x 16 array.
// Define LC3_MMIO_EN to add the keyboard/display device registers and their ports.
module lc3_mem_responder
   import lc3_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = LC3_MEM_LATENCY,
   parameter int unsigned ADDR_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] mar,
   input  logic [15:0] mdr_in,
   input  logic        mio_en,
   input  logic        r_w,
`ifdef LC3_MMIO_EN
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   input  logic        dsr_ready,
   output logic        ddr_valid,
   output logic [7:0]  ddr_data,
`endif
   output logic [15:0] mem_out,
   output logic        r
);

   localparam logic [3:0] LatInit = 4'(MEM_LATENCY - 1);

   logic [15:0] mem [2**ADDR_W];

   lc3_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic        wr_q;
   logic [15:0] mem_out_q;
   logic        r_q;
   logic        accept;
   logic        complete;
   logic        dev_hit;
   logic [15:0] rd_data;
   logic [ADDR_W-1:0] idx;

   assign idx = addr_q[ADDR_W-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      complete = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mio_en) begin
               accept  = 1'b1;
               cnt_d   = LatInit;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q == 4'd0) begin
               complete = 1'b1;
               state_d  = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

`ifdef LC3_MMIO_EN
   logic [15:0] dev_rdata;

   lc3_mmio u_mmio (
      .clk       (clk),
      .rst       (rst),
      .complete  (complete),
      .wr        (wr_q),
      .addr      (addr_q),
      .wdata     (wdata_q[7:0]),
      .kb_valid  (kb_valid),
      .kb_data   (kb_data),
      .dsr_ready (dsr_ready),
      .hit       (dev_hit),
      .rdata     (dev_rdata),
      .ddr_valid (ddr_valid),
      .ddr_data  (ddr_data)
   );

   assign rd_data = dev_hit ? dev_rdata : mem[idx];
`else
   assign dev_hit = 1'b0;
   assign rd_data = mem[idx];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         r_q       <= 1'b0;
         mem_out_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= complete;
         if (complete && !wr_q) mem_out_q <= rd_data;
      end
   end

   // Request capture; only meaningful once accepted, so no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= mar;
         wdata_q <= mdr_in;
         wr_q    <= r_w;
      end
   end

   // Array contents survive reset; a reset on the completion edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && complete && wr_q && !dev_hit) mem[idx] <= wdata_q;
   end

   assign mem_out = mem_out_q;
   assign r       = r_q;

endmodule

// File: doc/lc3_mem_responder.md
LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2: BUSY-state cycles per access; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 16: implemented memory address bits; array depth 2^ADDR_W x 16.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port mar  in  16  access address, sampled on request acceptance.
REQ-006 SHALL have port mdr_in  in  16  write data, sampled on request acceptance.
REQ-007 SHALL have port mio_en  in  1  access request.
REQ-008 SHALL have port r_w  in  1  1 = write, 0 = read; sampled on acceptance.
REQ-009 SHALL have port mem_out  out  16  read data, registered.
REQ-010 SHALL have port r  out  1  ready; one-cycle completion pulse.
REQ-011 SHALL have, under LC3_MMIO_EN only: kb_valid in 1; kb_data in 8; dsr_ready in 1; ddr_valid out 1; ddr_data out 8.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-013 SHALL accept a request only in IDLE with mio_en=1, capturing mar, mdr_in and r_w, and loading the counter with MEM_LATENCY-1.
REQ-014 SHALL ignore mio_en, mar, mdr_in and r_w while in BUSY or DONE.
REQ-015 SHALL decrement the counter in BUSY and perform the array access on the edge where it is 0, then enter DONE.
REQ-016 SHALL drive r=1 only in DONE, i.e. r high exactly MEM_LATENCY+1 cycles after the acceptance edge.
REQ-017 SHALL return DONE -> IDLE unconditionally; back-to-back requests are accepted the cycle after r.
REQ-018 SHALL update mem_out on read completion (valid when r=1); mem_out SHALL hold its value through writes and idle cycles.
REQ-019 SHALL use mar[ADDR_W-1:0] for indexing and ignore upper bits, so addresses alias/wrap.

Reset
REQ-020 SHALL, on clk edge with rst=1, set state=IDLE, counter=0, r=0, mem_out=16'h0000, and under LC3_MMIO_EN KBSR=0, KBDR=0, ddr_valid=0, ddr_data=0.
REQ-021 SHALL abort any in-flight access on reset without writing the array; array contents are not reset.
REQ-022 SHALL give rst priority over every other event in the same cycle.

Configuration
REQ-023 SHALL, with LC3_MMIO_EN defined, decode 16-bit full-address device registers xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR ahead of the array.
REQ-024 SHALL, with LC3_MMIO_EN: kb_valid=1 loads KBDR={8'h00,kb_data} and sets KBSR[15].
REQ-025 SHALL, with LC3_MMIO_EN: completed KBDR read clears KBSR[15]; if kb_valid arrives the same cycle, set wins and KBDR takes new data.
REQ-026 SHALL, with LC3_MMIO_EN: DSR reads {dsr_ready,15'b0}.
REQ-027 SHALL, with LC3_MMIO_EN: completed DDR write drives ddr_data=mdr_in[7:0] and ddr_valid=1 for exactly one cycle.
REQ-028 SHALL, with LC3_MMIO_EN: writes to KBSR, KBDR and DSR are dropped, with r still pulsed.
REQ-029 SHALL, without LC3_MMIO_EN, omit the MMIO ports and treat xFE00-xFE06 as ordinary memory.

Structure
REQ-030 SHALL place the FSM state enum, MMIO address constants and MEM_LATENCY default in shared package lc3_pkg.
REQ-031 SHALL implement the device registers in one sub-module lc3_mmio, instantiated only under LC3_MMIO_EN; the array and FSM stay in lc3_mem_responder.

Verification
REQ-032 SHALL cover: write x3000<=x1234, then read x3000 -> r high 3 cycles after each acceptance (MEM_LATENCY=2); mem_out=x1234.
REQ-033 SHALL cover: mio_en held high, mar changed x3000->x4000 mid-BUSY -> access completes to x3000; next request taken the cycle after r.
REQ-034 SHALL cover: rst pulsed in BUSY of write x5000<=xBEEF -> r never pulses; later read x5000 returns prior contents; mem_out=x0000 after reset.
REQ-035 SHALL cover, with LC3_MMIO_EN: kb_valid with kb_data=x41, read xFE00 -> x8000; read xFE02 -> x0041; read xFE00 -> x0000.
REQ-036 SHALL cover, with LC3_MMIO_EN: write xFE06<=x0A58 -> ddr_valid one cycle with ddr_data=x58; kb_valid coincident with KBDR-read completion -> KBSR[15]=1.
